seq_tx: RTL and testbench
=========================

// Module: seq_tx
// PURPOSE
//  Serial frame transmitter: the sending end of the single-bit serial line that the
//  Mealy sequence detector samples as x. Accepts a parallel word via valid/ready and
//  shifts out preamble, payload MSB-first, optional parity, then one gap bit.
//  Exposes its state code for debug/bench visibility, as the detector does.
// PARAMETERS
//  DATA_W    8        payload width in bits (>=1)
//  PRE_W     4        preamble width in bits (>=1)
//  PREAMBLE  4'b1011  preamble pattern, sent MSB first (width PRE_W)
// PORTS
//  clk        in   1        sole clock; all state updates on posedge
//  rst_n      in   1        synchronous active-low reset, sampled on posedge clk
//  din        in   DATA_W   payload word
//  din_valid  in   1        payload present
//  din_ready  out  1        block can accept a payload this cycle
//  x          out  1        serial output line (registered)
//  busy       out  1        frame in progress (any state except IDLE)
//  state      out  3        current state code (registered)
//  c          out  1        clock mirror, c = clk (combinational)
// BEHAVIOUR
//  - Reset (rst_n==0 at posedge): state=IDLE, x=0, busy=0, din_ready=1 after edge,
//    shift register and bit counter cleared. Mid-frame reset aborts the frame; no
//    partial bits after that edge; word is discarded, not retransmitted.
//  - State codes: IDLE=3'b000 PRE=3'b001 DATA=3'b010 PAR=3'b011 GAP=3'b100.
//  - din_ready = (state==IDLE) & rst_n; combinational from state only.
//  - IDLE: x=0. Accept on din_valid&din_ready: capture din, load counter=PRE_W-1,
//    go PRE. No accept -> stay IDLE.
//  - PRE: x=PREAMBLE[cnt], cnt counts down; at cnt==0 go DATA, cnt=DATA_W-1.
//  - DATA: x=word[cnt] (MSB first); at cnt==0 go PAR (macro on) or GAP (macro off).
//  - PAR: x=even parity = ^word; one cycle; go GAP.
//  - GAP: x=0 for one cycle; go IDLE.
//  - x is registered: first preamble bit is on x the cycle after the accept edge.
//  - Latency accept->first bit: 1 cycle. Frame occupancy on x: PRE_W+DATA_W+1(+1 PAR).
//  - Back-to-back with din_valid held high: accept every
//    PRE_W+DATA_W+2 (+1 PAR) cycles; IDLE lasts exactly one cycle between frames.
//  - din/din_valid ignored outside IDLE; captured word is stable through the frame.
//  - Counter width = clog2(max(PRE_W,DATA_W)); no wrap; counter only decrements to 0.
//  - Unused state codes 101..111 -> IDLE next cycle, x=0.
// CONFIGURATION
//  - SEQ_TX_PARITY_EN defined: PAR state present, even parity bit after payload.
//  - Undefined: PAR never entered (DATA -> GAP); code 3'b011 is unused -> IDLE.
//    Frame shortens by one cycle; all other timing unchanged.
// STRUCTURE
//  - Package seq_tx_pkg: state code localparams (ST_IDLE..ST_GAP), state width 3,
//    default PREAMBLE constant, shared with the detector-side bench.
//  - One sub-module seq_tx_shift: loadable DATA_W shift/index register with
//    down-counter and done flag; top holds FSM, output register and handshake.
// TESTING  (defaults, SEQ_TX_PARITY_EN defined unless noted)
//  1 Reset then din=8'hA5, one-cycle valid -> x: 1011 10100101 0 0, busy 14 cycles,
//    state 001x4,010x8,011,100 then 000.
//  2 din=8'h01 -> parity bit 1; frame x = 1011 00000001 1 0.
//  3 din_valid held high, din 8'h3C then 8'hC3 -> accepts 15 cycles apart, one
//    IDLE cycle with din_ready=1 between; din changes mid-frame do not affect x.
//  4 rst_n=0 during DATA bit 3 -> next edge x=0, state=000, din_ready=1; no residual
//    bits; new accept afterwards sends full preamble.
//  5 Macro undefined, din=8'hA5 -> x: 1011 10100101 0, state never 011, period 14.
//  6 din_valid=0 for 50 cycles after reset -> x=0, busy=0, state=000 throughout.

Source files
------------

// File: rtl/seq_tx_pkg.sv
// rtl/seq_tx_pkg.sv - state codes and default preamble shared by the serial transmitter and its bench
package seq_tx_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 3'b000,
      ST_PRE  = 3'b001,
      ST_DATA = 3'b010,
      ST_PAR  = 3'b011,
      ST_GAP  = 3'b100
   } state_t;

   localparam logic [3:0] PREAMBLE_DEFAULT = 4'b1011;

endpackage

// File: rtl/seq_tx_shift.sv
// rtl/seq_tx_shift.sv - captured payload word plus loadable bit-index down-counter with done flag
module seq_tx_shift
   import seq_tx_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] din,
   input  logic              word_load,
   input  logic              cnt_load,
   input  logic [CNT_W-1:0]  cnt_val,
   input  logic              cnt_dec,
   output logic [DATA_W-1:0] word,
   output logic [CNT_W-1:0]  cnt,
   output logic              done
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         word <= '0;
         cnt  <= '0;
      end else begin
         if (word_load) begin
            word <= din;
         end
         // The counter saturates at zero; it never wraps.
         if (cnt_load) begin
            cnt <= cnt_val;
         end else if (cnt_dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/seq_tx.sv
// rtl/seq_tx.sv - serial frame transmitter: preamble, MSB-first payload, optional parity, gap bit
// Even parity bit after the payload is enabled by defining SEQ_TX_PARITY_EN.
module seq_tx
   import seq_tx_pkg::*;
#(
   parameter int               DATA_W   = 8,
   parameter int               PRE_W    = 4,
   parameter logic [PRE_W-1:0] PREAMBLE = PRE_W'(PREAMBLE_DEFAULT)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [DATA_W-1:0]  din,
   input  logic               din_valid,
   output logic               din_ready,
   output logic               x,
   output logic               busy,
   output logic [STATE_W-1:0] state,
   output logic               c
);

   localparam int MAX_W = (PRE_W > DATA_W) ? PRE_W : DATA_W;
   localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
   localparam int EXT_W = 1 << CNT_W;
   localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   state_t             st;
   state_t             st_nxt;
   logic               x_nxt;
   logic               word_load;
   logic               cnt_load;
   logic [CNT_W-1:0]   cnt_val;
   logic               cnt_dec;
   logic [DATA_W-1:0]  word;
   logic [CNT_W-1:0]   cnt;
   logic               done;
   logic [CNT_W-1:0]   cnt_m1;
   logic [EXT_W-1:0]   pre_ext;
   logic [EXT_W-1:0]   word_ext;

   seq_tx_shift #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_shift (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
      .word_load (word_load),
      .cnt_load  (cnt_load),
      .cnt_val   (cnt_val),
      .cnt_dec   (cnt_dec),
      .word      (word),
      .cnt       (cnt),
      .done      (done)
   );

   // x is registered, so the bit computed here belongs to the state being entered.
   assign cnt_m1   = cnt - CNT_W'(1);
   assign pre_ext  = EXT_W'(PREAMBLE);
   assign word_ext = EXT_W'(word);

   always_comb begin
      st_nxt    = ST_IDLE;
      x_nxt     = 1'b0;
      word_load = 1'b0;
      cnt_load  = 1'b0;
      cnt_val   = '0;
      cnt_dec   = 1'b0;
      case (st)
         ST_IDLE: begin
            st_nxt = ST_IDLE;
            if (din_valid) begin
               st_nxt    = ST_PRE;
               word_load = 1'b1;
               cnt_load  = 1'b1;
               cnt_val   = PRE_LAST;
               x_nxt     = PREAMBLE[PRE_W-1];
            end
         end
         ST_PRE: begin
            if (done) begin
               st_nxt   = ST_DATA;
               cnt_load = 1'b1;
               cnt_val  = DATA_LAST;
               x_nxt    = word[DATA_W-1];
            end else begin
               st_nxt  = ST_PRE;
               cnt_dec = 1'b1;
               x_nxt   = pre_ext[cnt_m1];
            end
         end
         ST_DATA: begin
            if (done) begin
`ifdef SEQ_TX_PARITY_EN
               st_nxt = ST_PAR;
               x_nxt  = ^word;
`else
               st_nxt = ST_GAP;
               x_nxt  = 1'b0;
`endif
            end else begin
               st_nxt  = ST_DATA;
               cnt_dec = 1'b1;
               x_nxt   = word_ext[cnt_m1];
            end
         end
`ifdef SEQ_TX_PARITY_EN
         ST_PAR: begin
            st_nxt = ST_GAP;
         end
`endif
         ST_GAP: begin
            st_nxt = ST_IDLE;
         end
         default: begin
            st_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st <= ST_IDLE;
         x  <= 1'b0;
      end else begin
         st <= st_nxt;
         x  <= x_nxt;
      end
   end

   assign din_ready = (st == ST_IDLE) & rst_n;
   assign busy      = (st != ST_IDLE);
   assign state     = st;
   assign c         = clk;

endmodule

// File: tb/tb_seq_tx.sv
// tb/tb_seq_tx.sv - randomized self-checking bench for seq_tx against a frame-level reference model
module tb_seq_tx;

   localparam int DATA_W = 8;
   localparam int PRE_W  = 4;
`ifdef SEQ_TX_PARITY_EN
   localparam int PAR_EN = 1;
`else
   localparam int PAR_EN = 0;
`endif
   localparam int FL = PRE_W + DATA_W + 1 + PAR_EN;

   logic              clk;
   logic              rst_n;
   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic              din_ready;
   logic              x;
   logic              busy;
   logic [2:0]        state;
   logic              c;

   int errors = 0;
   int checks = 0;

   logic [PRE_W-1:0] pre_pat = 4'b1011;
   logic             exp_x[$];
   logic [2:0]       exp_st[$];

   seq_tx #(
      .DATA_W   (DATA_W),
      .PRE_W    (PRE_W),
      .PREAMBLE (4'b1011)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .x         (x),
      .busy      (busy),
      .state     (state),
      .c         (c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected line contents, one entry per cycle, built from the frame format.
   task automatic model_frame(input logic [DATA_W-1:0] w);
      logic [PRE_W-1:0]  p;
      logic [DATA_W-1:0] d;
      int ones;
      p = pre_pat;
      d = w;
      ones = 0;
      for (int k = 0; k < PRE_W; k++) begin
         exp_x.push_back(p[PRE_W-1]);
         exp_st.push_back(3'b001);
         p = p << 1;
      end
      for (int k = 0; k < DATA_W; k++) begin
         exp_x.push_back(d[DATA_W-1]);
         exp_st.push_back(3'b010);
         if (d[DATA_W-1]) ones++;
         d = d << 1;
      end
      if (PAR_EN != 0) begin
         exp_x.push_back((ones % 2) == 1);
         exp_st.push_back(3'b011);
      end
      exp_x.push_back(1'b0);
      exp_st.push_back(3'b100);
   endtask

   task automatic model_idle();
      exp_x.push_back(1'b0);
      exp_st.push_back(3'b000);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      din_valid = 1'b0;
      din = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (state !== 3'b000) begin errors++; $display("FAIL reset_state got=%b exp=000", state); end
      checks++; if (x !== 1'b0) begin errors++; $display("FAIL reset_x got=%b exp=0", x); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low got=%b exp=0", din_ready); end
      checks++; if (c !== clk) begin errors++; $display("FAIL clock_mirror got=%b exp=%b", c, clk); end
      rst_n = 1'b1;
      #1;
      checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_high got=%b exp=1", din_ready); end
      @(posedge clk);
      #1;
      checks++; if (c !== clk) begin errors++; $display("FAIL clock_mirror_hi got=%b exp=%b", c, clk); end
      @(negedge clk);
   endtask

   task automatic test_idle();
      din_valid = 1'b0;
      for (int i = 0; i < 50; i++) begin
         din = DATA_W'($urandom);
         @(negedge clk);
         checks++; if (x !== 1'b0) begin errors++; $display("FAIL idle_x cyc=%0d got=%b exp=0", i, x); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy cyc=%0d got=%b exp=0", i, busy); end
         checks++; if (state !== 3'b000) begin errors++; $display("FAIL idle_state cyc=%0d got=%b exp=000", i, state); end
      end
   endtask

   task automatic test_frames();
      logic [DATA_W-1:0] words[$];
      words.push_back(8'hA5);
      words.push_back(8'h01);
      for (int n = 0; n < 6; n++) words.push_back(DATA_W'($urandom));
      foreach (words[n]) begin
         exp_x.delete();
         exp_st.delete();
         model_frame(words[n]);
         model_idle();
         din = words[n];
         din_valid = 1'b1;
         checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL frame_ready w=%h got=%b exp=1", words[n], din_ready); end
         for (int i = 0; i < exp_x.size(); i++) begin
            @(negedge clk);
            din_valid = 1'b0;
            din = DATA_W'($urandom);
            checks++; if (x !== exp_x[i]) begin errors++; $display("FAIL frame_x w=%h cyc=%0d got=%b exp=%b", words[n], i, x, exp_x[i]); end
            checks++; if (state !== exp_st[i]) begin errors++; $display("FAIL frame_state w=%h cyc=%0d got=%b exp=%b", words[n], i, state, exp_st[i]); end
            checks++; if (busy !== (exp_st[i] != 3'b000)) begin errors++; $display("FAIL frame_busy w=%h cyc=%0d got=%b", words[n], i, busy); end
            checks++; if (din_ready !== (exp_st[i] == 3'b000)) begin errors++; $display("FAIL frame_din_ready w=%h cyc=%0d got=%b", words[n], i, din_ready); end
         end
      end
   endtask

   task automatic test_back_to_back();
      int accepts[$];
      int last;
      exp_x.delete();
      exp_st.delete();
      model_frame(8'h3C);
      model_idle();
      model_frame(8'hC3);
      model_idle();
      last = exp_x.size() - 1;
      din = 8'h3C;
      din_valid = 1'b1;
      if (din_ready === 1'b1) accepts.push_back(0);
      for (int j = 0; j <= last; j++) begin
         @(negedge clk);
         checks++; if (x !== exp_x[j]) begin errors++; $display("FAIL b2b_x cyc=%0d got=%b exp=%b", j, x, exp_x[j]); end
         checks++; if (state !== exp_st[j]) begin errors++; $display("FAIL b2b_state cyc=%0d got=%b exp=%b", j, state, exp_st[j]); end
         checks++; if (din_ready !== (exp_st[j] == 3'b000)) begin errors++; $display("FAIL b2b_ready cyc=%0d got=%b", j, din_ready); end
         if (j != last && din_ready === 1'b1) accepts.push_back(j + 1);
         if (j == FL) din = 8'hC3;
         else din = DATA_W'($urandom);
         if (j == last) din_valid = 1'b0;
      end
      checks++;
      if (accepts.size() != 2) begin
         errors++; $display("FAIL b2b_accept_count got=%0d exp=2", accepts.size());
      end else if (accepts[1] - accepts[0] != FL + 1) begin
         errors++; $display("FAIL b2b_period got=%0d exp=%0d", accepts[1] - accepts[0], FL + 1);
      end
   endtask

   task automatic test_mid_reset();
      logic [DATA_W-1:0] w;
      int stop;
      w = DATA_W'($urandom);
      exp_x.delete();
      exp_st.delete();
      model_frame(w);
      stop = PRE_W + DATA_W - 4;
      din = w;
      din_valid = 1'b1;
      for (int j = 0; j <= stop; j++) begin
         @(negedge clk);
         din_valid = 1'b0;
         checks++; if (x !== exp_x[j]) begin errors++; $display("FAIL midrst_x cyc=%0d got=%b exp=%b", j, x, exp_x[j]); end
      end
      checks++; if (state !== 3'b010) begin errors++; $display("FAIL midrst_in_data got=%b exp=010", state); end
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (x !== 1'b0) begin errors++; $display("FAIL midrst_x_clear got=%b exp=0", x); end
      checks++; if (state !== 3'b000) begin errors++; $display("FAIL midrst_state got=%b exp=000", state); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++; if (x !== 1'b0) begin errors++; $display("FAIL midrst_residual_x cyc=%0d got=%b exp=0", i, x); end
         checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready cyc=%0d got=%b exp=1", i, din_ready); end
      end
      w = DATA_W'($urandom);
      exp_x.delete();
      exp_st.delete();
      model_frame(w);
      model_idle();
      din = w;
      din_valid = 1'b1;
      for (int i = 0; i < exp_x.size(); i++) begin
         @(negedge clk);
         din_valid = 1'b0;
         checks++; if (x !== exp_x[i]) begin errors++; $display("FAIL postrst_x w=%h cyc=%0d got=%b exp=%b", w, i, x, exp_x[i]); end
         checks++; if (state !== exp_st[i]) begin errors++; $display("FAIL postrst_state w=%h cyc=%0d got=%b exp=%b", w, i, state, exp_st[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_frames();
      test_back_to_back();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
